// File: rtl/dsp_mac_pipe.sv
// Three-stage multiply-accumulate slice: pre-adder, multiplier, post-adder/accumulator.
// Optional build macro DSP_MAC_SAT_EN: saturate p on carry/borrow instead of wrapping.
module dsp_mac_pipe #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic [B_WIDTH-1:0] d,
  input  logic [P_WIDTH-1:0] c,
  input  logic [3:0]         opmode,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] p,
  output logic               carryout,
  output logic               overflow
);

  generate
    if (P_WIDTH < A_WIDTH + B_WIDTH) begin : g_width_check
      $error("dsp_mac_pipe: P_WIDTH must be >= A_WIDTH + B_WIDTH");
    end
  endgenerate

  // Pre-adder result, truncated to B_WIDTH (modulo)
  function automatic logic [B_WIDTH-1:0] pre_add(
    input logic             sub,
    input logic [B_WIDTH-1:0] dv,
    input logic [B_WIDTH-1:0] bv
  );
    if (sub) begin
      return dv - bv;
    end else begin
      return dv + bv;
    end
  endfunction

  // Post-add with carry/borrow in bit P_WIDTH
  function automatic logic [P_WIDTH:0] post_add(
    input logic [1:0]         sel,
    input logic [P_WIDTH-1:0] acc,
    input logic [P_WIDTH-1:0] m,
    input logic [P_WIDTH-1:0] cin
  );
    case (sel)
      2'b00:   return {1'b0, m};
      2'b01:   return {1'b0, m} + {1'b0, cin};
      2'b10:   return {1'b0, acc} + {1'b0, m};
      2'b11:   return {1'b0, acc} - {1'b0, m};
      default: return {1'b0, m};
    endcase
  endfunction

  // Stage 1 registers
  logic [A_WIDTH-1:0] a1_q, a1_d;
  logic [B_WIDTH-1:0] opnd1_q, opnd1_d;
  logic [P_WIDTH-1:0] c1_q, c1_d;
  logic [1:0]         sel1_q, sel1_d;
  logic               v1_q, v1_d;

  // Stage 2 registers
  logic [P_WIDTH-1:0] m2_q, m2_d;
  logic [P_WIDTH-1:0] c2_q, c2_d;
  logic [1:0]         sel2_q, sel2_d;
  logic               v2_q, v2_d;

  // Stage 3 / output registers
  logic [P_WIDTH-1:0] p_q, p_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               vout_q, vout_d;

  logic [B_WIDTH-1:0] pre_s;
  logic [P_WIDTH-1:0] prod_s;
  logic [P_WIDTH:0]   sum_s;

  assign pre_s  = pre_add(opmode[1], d, b);
  assign prod_s = P_WIDTH'(a1_q) * P_WIDTH'(opnd1_q);
  assign sum_s  = post_add(sel2_q, p_q, m2_q, c2_q);

  // Stage 1 next state: capture operands and select the multiplier operand
  always_comb begin
    a1_d    = a1_q;
    opnd1_d = opnd1_q;
    c1_d    = c1_q;
    sel1_d  = sel1_q;
    v1_d    = v1_q;
    if (ce) begin
      a1_d   = a;
      c1_d   = c;
      sel1_d = opmode[3:2];
      v1_d   = in_valid;
      if (opmode[0]) begin
        opnd1_d = pre_s;
      end else begin
        opnd1_d = b;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 2 next state: multiply; the product always fits in P_WIDTH
  always_comb begin
    m2_d   = m2_q;
    c2_d   = c2_q;
    sel2_d = sel2_q;
    v2_d   = v2_q;
    if (ce) begin
      m2_d   = prod_s;
      c2_d   = c1_q;
      sel2_d = sel1_q;
      v2_d   = v1_q;
    end else begin
      v2_d = v2_q;
    end
  end

  // Stage 3 next state: post-add into p; bubbles leave p and flags untouched
  always_comb begin
    p_d     = p_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    vout_d  = vout_q;
    if (ce) begin
      vout_d = v2_q;
      if (v2_q) begin
        carry_d = sum_s[P_WIDTH];
`ifdef DSP_MAC_SAT_EN
        if (sum_s[P_WIDTH]) begin
          if (sel2_q == 2'b11) begin
            p_d = {P_WIDTH{1'b0}};
          end else begin
            p_d = {P_WIDTH{1'b1}};
          end
        end else begin
          p_d = sum_s[P_WIDTH-1:0];
        end
`else
        p_d = sum_s[P_WIDTH-1:0];
`endif
        // Start ops (00/01) restart the sticky flag, accumulate ops OR into it
        if (sel2_q[1]) begin
          ovf_d = ovf_q | sum_s[P_WIDTH];
        end else begin
          ovf_d = sum_s[P_WIDTH];
        end
      end else begin
        p_d = p_q;
      end
    end else begin
      vout_d = vout_q;
    end
  end

  // Pipeline registers; rst overrides ce
  always_ff @(posedge clk) begin
    if (rst) begin
      a1_q    <= {A_WIDTH{1'b0}};
      opnd1_q <= {B_WIDTH{1'b0}};
      c1_q    <= {P_WIDTH{1'b0}};
      sel1_q  <= 2'b00;
      v1_q    <= 1'b0;
      m2_q    <= {P_WIDTH{1'b0}};
      c2_q    <= {P_WIDTH{1'b0}};
      sel2_q  <= 2'b00;
      v2_q    <= 1'b0;
      p_q     <= {P_WIDTH{1'b0}};
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      vout_q  <= 1'b0;
    end else begin
      a1_q    <= a1_d;
      opnd1_q <= opnd1_d;
      c1_q    <= c1_d;
      sel1_q  <= sel1_d;
      v1_q    <= v1_d;
      m2_q    <= m2_d;
      c2_q    <= c2_d;
      sel2_q  <= sel2_d;
      v2_q    <= v2_d;
      p_q     <= p_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      vout_q  <= vout_d;
    end
  end

  assign out_valid = vout_q;
  assign p         = p_q;
  assign carryout  = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed self-checking bench for dsp_mac_pipe with default widths (18/18/48).
module tb_dsp_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic [17:0] a, b, d;
  logic [47:0] c;
  logic [3:0]  opmode;
  logic        out_valid;
  logic [47:0] p;
  logic        carryout;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .d(d), .c(c), .opmode(opmode),
    .out_valid(out_valid), .p(p), .carryout(carryout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic ce_i, input logic v_i, input logic [17:0] a_i,
                       input logic [17:0] b_i, input logic [17:0] d_i,
                       input logic [47:0] c_i, input logic [3:0] op_i);
    ce = ce_i; in_valid = v_i; a = a_i; b = b_i; d = d_i; c = c_i; opmode = op_i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 18'd5, 18'd5, 18'd0, 48'd0, 4'b0000);
    tick(); tick(); tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b0000);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (p !== 48'd0) begin errors++; $display("FAIL reset_p: got %0d expected 0", p); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("FAIL reset_carryout: got %b expected 0", carryout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 18'd3, 18'd4, 18'd0, 48'd0, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b0000);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_n: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_n1: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_lat_n2: got %b expected 1", out_valid); end
    checks++; if (p !== 48'd12) begin errors++; $display("FAIL basic_p: got %0d expected 12", p); end
    checks++; if (carryout !== 1'b0) begin errors++; $display("FAIL basic_carry: got %b expected 0", carryout); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", out_valid); end
    checks++; if (p !== 48'd12) begin errors++; $display("FAIL basic_hold: got %0d expected 12", p); end
  endtask

  task automatic test_preadd();
    logic [17:0] ta [3] = '{18'd2, 18'd2, 18'd2};
    logic [17:0] tb [3] = '{18'd3, 18'd3, 18'd1};
    logic [17:0] td [3] = '{18'd10, 18'd10, 18'd0};
    logic [3:0]  to [3] = '{4'b0001, 4'b0011, 4'b0011};
    logic [47:0] ex [3] = '{48'd26, 48'd14, 48'd524286};
    for (int s = 0; s < 5; s++) begin
      if (s < 3) drive(1'b1, 1'b1, ta[s], tb[s], td[s], 48'd0, to[s]);
      else       drive(1'b1, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b0000);
      tick();
      if (s >= 2) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL preadd_valid[%0d]: got %b expected 1", s - 2, out_valid); end
        checks++; if (p !== ex[s-2]) begin errors++; $display("FAIL preadd_p[%0d]: got %0d expected %0d", s - 2, p, ex[s-2]); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL preadd_fill[%0d]: got %b expected 0", s, out_valid); end
      end
    end
  endtask

  task automatic test_accumulate();
    logic [17:0] ta [5] = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd1};
    logic [3:0]  to [5] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0100};
    logic [47:0] tc [5] = '{48'd0, 48'd0, 48'd0, 48'd0, 48'd7};
    logic [47:0] ex [5] = '{48'd5, 48'd15, 48'd30, 48'd50, 48'd12};
    for (int s = 0; s < 7; s++) begin
      if (s < 5) drive(1'b1, 1'b1, ta[s], 18'd5, 18'd0, tc[s], to[s]);
      else       drive(1'b1, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b0000);
      tick();
      if (s >= 2) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL acc_valid[%0d]: got %b expected 1", s - 2, out_valid); end
        checks++; if (p !== ex[s-2]) begin errors++; $display("FAIL acc_p[%0d]: got %0d expected %0d", s - 2, p, ex[s-2]); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL acc_ovf[%0d]: got %b expected 0", s - 2, overflow); end
      end
    end
  endtask

  task automatic test_borrow();
    logic [17:0] tb [5] = '{18'd5, 18'd10, 18'd1, 18'd5, 18'd1};
    logic [3:0]  to [5] = '{4'b0000, 4'b1100, 4'b1000, 4'b1000, 4'b0000};
`ifdef DSP_MAC_SAT_EN
    logic [47:0] ep [5] = '{48'd5, 48'd0, 48'd1, 48'd6, 48'd1};
    logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    logic [47:0] ep [5] = '{48'd5, 48'hFFFF_FFFF_FFFB, 48'hFFFF_FFFF_FFFC, 48'd1, 48'd1};
    logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    logic        eo [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int s = 0; s < 7; s++) begin
      if (s < 5) drive(1'b1, 1'b1, 18'd1, tb[s], 18'd0, 48'd0, to[s]);
      else       drive(1'b1, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b0000);
      tick();
      if (s >= 2) begin
        checks++; if (p !== ep[s-2]) begin errors++; $display("FAIL borrow_p[%0d]: got %0h expected %0h", s - 2, p, ep[s-2]); end
        checks++; if (carryout !== ec[s-2]) begin errors++; $display("FAIL borrow_carry[%0d]: got %b expected %b", s - 2, carryout, ec[s-2]); end
        checks++; if (overflow !== eo[s-2]) begin errors++; $display("FAIL borrow_ovf[%0d]: got %b expected %b", s - 2, overflow, eo[s-2]); end
      end
    end
  endtask

  task automatic test_stall();
    logic        tce [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        tv  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [17:0] ta  [9] = '{18'd3, 18'd0, 18'd2, 18'd0, 18'd9, 18'd9, 18'd1, 18'd0, 18'd0};
    logic [3:0]  to  [9] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic        ev  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [47:0] ep  [9] = '{48'd1, 48'd1, 48'd21, 48'd21, 48'd21, 48'd21, 48'd35, 48'd35, 48'd42};
    for (int s = 0; s < 9; s++) begin
      drive(tce[s], tv[s], ta[s], 18'd7, 18'd0, 48'd0, to[s]);
      tick();
      checks++; if (out_valid !== ev[s]) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected %b", s, out_valid, ev[s]); end
      checks++; if (p !== ep[s]) begin errors++; $display("FAIL stall_p[%0d]: got %0d expected %0d", s, p, ep[s]); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 18'd1, 18'd100, 18'd0, 48'd0, 4'b1100);
    tick();
    drive(1'b1, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b0000);
    tick(); tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre_ovf: got %b expected 1", overflow); end
    drive(1'b1, 1'b1, 18'd5, 18'd5, 18'd0, 48'd0, 4'b0000);
    tick();
    drive(1'b1, 1'b1, 18'd6, 18'd6, 18'd0, 48'd0, 4'b0000);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b0000);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b0000);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
    checks++; if (p !== 48'd0) begin errors++; $display("FAIL rmid_p: got %0d expected 0", p); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf: got %b expected 0", overflow); end
    for (int s = 0; s < 2; s++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_flush_valid[%0d]: got %b expected 0", s, out_valid); end
      checks++; if (p !== 48'd0) begin errors++; $display("FAIL rmid_flush_p[%0d]: got %0d expected 0", s, p); end
    end
    drive(1'b1, 1'b1, 18'd2, 18'd3, 18'd0, 48'd0, 4'b1000);
    tick();
    drive(1'b1, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b0000);
    tick(); tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_after_valid: got %b expected 1", out_valid); end
    checks++; if (p !== 48'd6) begin errors++; $display("FAIL rmid_after_p: got %0d expected 6", p); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_after_ovf: got %b expected 0", overflow); end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b0000);
    test_reset();
    test_basic();
    test_preadd();
    test_accumulate();
    test_borrow();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
